// File: rtl/hps_pixel_receiver.sv
// hps_pixel_receiver: HPS Avalon-MM pixel sink feeding the SDRAM write FIFO; zero-wait reads, push to pix_wr in 1 cycle.
// waitrequest only while ACTIVE with the FIFO full and nothing popping; HPS_RX_RGB565_EN packs RGB888 to RGB565.
module hps_pixel_receiver #(
   parameter int FRAME_PIXELS = 307200,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  address,
   input  logic        read,
   output logic [31:0] readdata,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic        waitrequest,
   output logic [15:0] pix_out,
   output logic        pix_wr,
   input  logic        pix_wr_full,
   output logic        frame_start,
   output logic        frame_done
);
   localparam int              AW        = $clog2(FIFO_DEPTH);
   localparam int              LVL_W     = AW + 1;
   localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
   localparam logic [23:0]     FRAME_CNT = 24'(FRAME_PIXELS);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [15:0]      mem_q [FIFO_DEPTH];
   logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level;
   logic             fifo_empty, fifo_full;
   logic [23:0]      cnt_q, cnt_d;
   logic             err_idle_q, err_idle_d, err_over_q, err_over_d;
   logic             frame_start_q;
   logic             streaming, pix_req, ctl_wr, start_cmd, abort_cmd, push, pop;
   logic [15:0]      push_dat;
   logic [31:0]      status;

`ifdef HPS_RX_RGB565_EN
   logic unused_wd;
   assign unused_wd = ^{writedata[31:24], writedata[18:16], writedata[9:8], writedata[2:0]};
   assign push_dat  = {writedata[23:19], writedata[15:10], writedata[7:3]};
`else
   logic unused_wd;
   assign unused_wd = ^writedata[31:16];
   assign push_dat  = writedata[15:0];
`endif

   // Pointers carry one extra wrap bit so full and empty differ without a separate flag.
   assign level       = wr_ptr_q - rd_ptr_q;
   assign fifo_empty  = (level == '0);
   assign fifo_full   = (level == DEPTH_LVL);
   assign streaming   = (state_q == S_ACTIVE) || (state_q == S_DRAIN);

   assign pix_wr      = !fifo_empty && !pix_wr_full && streaming;
   assign pop         = pix_wr;
   assign pix_out     = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q[AW-1:0]];

   assign waitrequest = write && (address == 3'd0) && (state_q == S_ACTIVE) && fifo_full && !pix_wr;
   assign pix_req     = write && (address == 3'd0) && !waitrequest;
   assign ctl_wr      = write && (address == 3'd1);
   assign abort_cmd   = ctl_wr && writedata[1];
   assign start_cmd   = ctl_wr && writedata[0] && !writedata[1];
   assign push        = pix_req && (state_q == S_ACTIVE) && (cnt_q < FRAME_CNT);

   assign frame_start = frame_start_q;
   assign frame_done  = (state_q == S_DONE);

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      err_idle_d = err_idle_q;
      err_over_d = err_over_q;
      if (abort_cmd) begin
         state_d  = S_IDLE;
         rd_ptr_d = wr_ptr_q;
         cnt_d    = '0;
      end else if (start_cmd) begin
         state_d    = S_ACTIVE;
         rd_ptr_d   = wr_ptr_q;
         cnt_d      = '0;
         err_idle_d = 1'b0;
         err_over_d = 1'b0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + LVL_W'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + LVL_W'(1);
            cnt_d    = cnt_q + 24'd1;
         end
         if (pix_req && (state_q != S_ACTIVE)) begin
            err_idle_d = 1'b1;
         end
         if (pix_req && (state_q == S_ACTIVE) && (cnt_q >= FRAME_CNT)) begin
            err_over_d = 1'b1;
         end
         // Leaving ACTIVE on the accepting edge keeps err_over a pure guard.
         case (state_q)
            S_ACTIVE: if (cnt_d >= FRAME_CNT) state_d = S_DRAIN;
            S_DRAIN:  if (fifo_empty) state_d = S_DONE;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         cnt_q         <= '0;
         err_idle_q    <= 1'b0;
         err_over_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         cnt_q         <= cnt_d;
         err_idle_q    <= err_idle_d;
         err_over_q    <= err_over_d;
         frame_start_q <= start_cmd;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
      end
   end

   always_comb begin
      status        = 32'h0;
      status[0]     = streaming;
      status[1]     = (state_q == S_DONE);
      status[2]     = fifo_full;
      status[3]     = err_idle_q;
      status[4]     = err_over_q;
      status[15:8]  = 8'(level);
      readdata      = 32'h0;
      if (read) begin
         case (address)
            3'd2:    readdata = status;
            3'd3:    readdata = {8'h00, cnt_q};
            default: readdata = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_hps_pixel_receiver.sv
// Bench for hps_pixel_receiver: queue-based frame model checked every cycle plus directed literal checks.
module tb_hps_pixel_receiver;
   localparam int FP    = 8;
   localparam int DEPTH = 4;
`ifdef HPS_RX_RGB565_EN
   localparam logic [15:0] EXP_RED  = 16'hF800;
   localparam logic [15:0] EXP_LAST = 16'h11AA;
`else
   localparam logic [15:0] EXP_RED  = 16'h0000;
   localparam logic [15:0] EXP_LAST = 16'h3456;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  address;
   logic        read;
   logic [31:0] readdata;
   logic        write;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [15:0] pix_out;
   logic        pix_wr;
   logic        pix_wr_full;
   logic        frame_start;
   logic        frame_done;

   hps_pixel_receiver #(.FRAME_PIXELS(FP), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .address(address), .read(read), .readdata(readdata),
      .write(write), .writedata(writedata), .waitrequest(waitrequest),
      .pix_out(pix_out), .pix_wr(pix_wr), .pix_wr_full(pix_wr_full),
      .frame_start(frame_start), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Frame model: mode follows the frame life cycle, mq holds pixels not yet sent.
   typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mode_t;
   logic [15:0] mq[$];
   mode_t       m_mode = M_IDLE;
   int          m_cnt = 0;
   bit          m_eidle = 0, m_eover = 0, m_fs = 0, m_ok = 0;
   int          pixwr_cycles = 0, fs_pulses = 0;
   logic [15:0] last_pix = 16'hDEAD;

   function automatic logic [15:0] conv(input logic [31:0] wd);
`ifdef HPS_RX_RGB565_EN
      return {wd[23:19], wd[15:10], wd[7:3]};
`else
      return wd[15:0];
`endif
   endfunction

   function automatic bit e_pixwr();
      return (mq.size() > 0) && !pix_wr_full && (m_mode == M_RUN || m_mode == M_DRAIN);
   endfunction

   function automatic bit e_wait();
      return write && (address == 3'd0) && (m_mode == M_RUN) && (mq.size() == DEPTH) && !e_pixwr();
   endfunction

   function automatic logic [31:0] e_rd();
      if (!read) return 32'h0;
      if (address == 3'd2)
         return {16'h0, 8'(mq.size()), 3'b000, m_eover, m_eidle, mq.size() == DEPTH,
                 m_mode == M_DONE, m_mode == M_RUN || m_mode == M_DRAIN};
      if (address == 3'd3) return 32'(m_cnt);
      return 32'h0;
   endfunction

   always @(posedge clk) begin : model
      bit    pop, pw, ctl;
      mode_t old_mode;
      int    old_size;
      if (rst) begin
         mq.delete();
         m_mode = M_IDLE; m_cnt = 0; m_eidle = 0; m_eover = 0; m_fs = 0; m_ok = 1;
      end else begin
         pop = e_pixwr();
         pw  = write && (address == 3'd0) && !e_wait();
         ctl = write && (address == 3'd1);
         old_mode = m_mode;
         old_size = mq.size();
         m_fs = 0;
         if (ctl && writedata[1]) begin
            mq.delete(); m_mode = M_IDLE; m_cnt = 0;
         end else if (ctl && writedata[0]) begin
            mq.delete(); m_mode = M_RUN; m_cnt = 0; m_eidle = 0; m_eover = 0; m_fs = 1;
         end else begin
            if (pop) void'(mq.pop_front());
            if (pw) begin
               if (old_mode == M_RUN && m_cnt < FP) begin
                  mq.push_back(conv(writedata));
                  m_cnt++;
                  if (m_cnt == FP) m_mode = M_DRAIN;
               end else if (old_mode == M_RUN) m_eover = 1;
               else m_eidle = 1;
            end
            if (old_mode == M_DRAIN && old_size == 0) m_mode = M_DONE;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("pix_wr", pix_wr, e_pixwr());
         if (e_pixwr()) chk("pix_out", pix_out, mq[0]);
         chk("waitrequest", waitrequest, e_wait());
         chk("frame_start", frame_start, m_fs);
         chk("frame_done", frame_done, m_mode == M_DONE);
         chk("readdata", readdata, e_rd());
         if (pix_wr === 1'b1) begin
            pixwr_cycles++;
            last_pix = pix_out;
         end
         if (frame_start === 1'b1) fs_pulses++;
      end
   end

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input int max_cyc,
                         output bit acc, output bit stalled);
      acc = 0; stalled = 0;
      address = a; writedata = d; write = 1'b1;
      for (int i = 0; i < max_cyc && !acc; i++) begin
         @(negedge clk);
         if (waitrequest) stalled = 1; else acc = 1;
         @(posedge clk); #1;
      end
      write = 1'b0; address = 3'd0; writedata = 32'h0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bit acc, st;
      bus_wr(a, d, 20, acc, st);
      chk("wr_accept", acc, 1'b1);
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a; read = 1'b1;
      @(negedge clk);
      d = readdata;
      @(posedge clk); #1;
      read = 1'b0; address = 3'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_done(input int limit);
      for (int i = 0; i < limit && frame_done !== 1'b1; i++) idle(1);
      chk("frame_done_wait", frame_done, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      bit acc, st;
      int base, fs0;
      rst = 1'b1; read = 1'b0; write = 1'b0; address = 3'd0; writedata = 32'h0; pix_wr_full = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("t1_pix_wr", pix_wr, 1'b0);
      chk("t1_pix_out", pix_out, 16'h0);
      chk("t1_waitreq", waitrequest, 1'b0);
      chk("t1_done", frame_done, 1'b0);
      rd(3'd2, d); chk("t1_status", d, 32'h0);
      rd(3'd3, d); chk("t1_count", d, 32'h0);

      base = pixwr_cycles; fs0 = fs_pulses;
      wr(3'd1, 32'h1);
      for (int i = 0; i < FP; i++) wr(3'd0, 32'h00FF0000);
      wait_done(20);
      chk("t2_pixwr_cycles", pixwr_cycles - base, 8);
      chk("t2_fs_pulses", fs_pulses - fs0, 1);
      chk("t2_pix_out", last_pix, EXP_RED);
      rd(3'd2, d); chk("t2_status", d, 32'h02);
      rd(3'd3, d); chk("t2_count", d, 32'd8);

      pix_wr_full = 1'b1;
      wr(3'd1, 32'h1);
      for (int i = 0; i < 4; i++) wr(3'd0, 32'h00102030 + 32'(i));
      bus_wr(3'd0, 32'h00555555, 3, acc, st);
      chk("t3_fifth_accept", acc, 1'b0);
      chk("t3_fifth_stall", st, 1'b1);
      rd(3'd2, d); chk("t3_status", d, 32'h0405);
      rd(3'd3, d); chk("t3_count4", d, 32'd4);
      pix_wr_full = 1'b0;
      bus_wr(3'd0, 32'h00555555, 3, acc, st);
      chk("t3_release_accept", acc, 1'b1);
      chk("t3_release_stall", st, 1'b0);
      rd(3'd3, d); chk("t3_count5", d, 32'd5);
      wr(3'd1, 32'h2);
      idle(2);

      base = pixwr_cycles;
      wr(3'd0, 32'h0000ABCD);
      rd(3'd2, d); chk("t4_status", d, 32'h08);
      rd(3'd3, d); chk("t4_count", d, 32'd0);
      chk("t4_no_pix_wr", pixwr_cycles - base, 0);

      pix_wr_full = 1'b1;
      wr(3'd1, 32'h1);
      for (int i = 0; i < 3; i++) wr(3'd0, 32'h00AA5500 + 32'(i));
      rd(3'd2, d); chk("t5_status_pre", d, 32'h0301);
      wr(3'd1, 32'h2);
      rd(3'd2, d); chk("t5_status", d, 32'h0);
      rd(3'd3, d); chk("t5_count", d, 32'd0);
      base = pixwr_cycles;
      pix_wr_full = 1'b0;
      idle(4);
      chk("t5_no_pix_wr", pixwr_cycles - base, 0);
      fs0 = fs_pulses;
      wr(3'd1, 32'h3);
      idle(1);
      rd(3'd2, d); chk("t5_abort_wins", d, 32'h0);
      chk("t5_no_start", fs_pulses - fs0, 0);

      pix_wr_full = 1'b1;
      wr(3'd1, 32'h1);
      for (int i = 0; i < 3; i++) wr(3'd0, 32'h00777777);
      pix_wr_full = 1'b0;
      wr(3'd1, 32'h1);
      rd(3'd3, d); chk("t6_restart_count", d, 32'd0);
      for (int i = 0; i < FP - 1; i++) wr(3'd0, 32'h00100000 * 32'(i + 1) + 32'(i));
      wr(3'd0, 32'h00123456);
      wait_done(20);
      chk("t6_last_pix", last_pix, EXP_LAST);
      wr(3'd0, 32'h00999999);
      rd(3'd2, d); chk("t6_status", d, 32'h0A);
      rd(3'd3, d); chk("t6_count", d, 32'd8);
      rd(3'd5, d); chk("t6_unmapped_rd", d, 32'h0);
      wr(3'd6, 32'hFFFFFFFF);
      rd(3'd2, d); chk("t6_unmapped_wr", d, 32'h0A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
